round_robin_lock_arbiter: RTL and testbench
===========================================

ROUND_ROBIN_LOCK_ARBITER -- requirements
Module: round_robin_lock_arbiter

Interface
REQ-001 SHALL have parameter REQ_WIDTH, default 4, number of requesters (>=1).
REQ-002 SHALL have parameter MAX_HOLD, default 16, max grant cycles before forced release; 0 disables the timeout.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port req  input  REQ_WIDTH  request per requester; bit i = requester i.
REQ-006 SHALL have port done  input  1  current holder ends its transaction this cycle.
REQ-007 SHALL have port grant  output  REQ_WIDTH  registered grant, one-hot or zero.
REQ-008 SHALL have port grant_valid  output  1  registered; high exactly when grant != 0.
REQ-009 SHALL have port grant_id  output  max(1,$clog2(REQ_WIDTH))  registered index of the set grant bit; 0 when grant_valid=0.
REQ-010 SHALL have port timeout  output  1  registered one-cycle pulse on forced release.

Function
REQ-011 SHALL implement two states: IDLE (grant=0) and BUSY (one requester holds grant).
REQ-012 SHALL keep a priority pointer ptr in 0..REQ_WIDTH-1; search order ptr, ptr+1, ..., REQ_WIDTH-1, 0, ..., ptr-1.
REQ-013 IDLE, req!=0 at an edge: SHALL select the first set req bit in search order, drive grant/grant_id/grant_valid from that edge, enter BUSY (1-cycle req-to-grant latency).
REQ-014 IDLE, req=0: SHALL stay IDLE; done ignored in IDLE.
REQ-015 BUSY: grant, grant_id SHALL stay constant irrespective of other req bits.
REQ-016 BUSY release conditions, sampled each edge: done=1; or req[holder]=0; or hold count = MAX_HOLD (MAX_HOLD>0).
REQ-017 On release edge: SHALL return to IDLE, grant=0, grant_valid=0, ptr = (holder+1) mod REQ_WIDTH, wrapping at REQ_WIDTH-1 to 0.
REQ-018 SHALL insert exactly one IDLE bubble cycle between consecutive grants; next arbitration uses the updated ptr.
REQ-019 Hold counter SHALL be 1 in the first granted cycle, increment each BUSY cycle, clear on release; width sufficient for MAX_HOLD without overflow.
REQ-020 Forced release (count = MAX_HOLD, done=0, req[holder]=1): timeout SHALL be 1 for exactly the first IDLE cycle after release, else 0.
REQ-021 done=1 or req[holder]=0 in the same cycle the count reaches MAX_HOLD: normal release, timeout SHALL stay 0.
REQ-022 ptr SHALL change only on release; never on grant.
REQ-023 REQ_WIDTH=1: SHALL grant requester 0 whenever req[0]=1, grant_id=0, same hold/timeout rules.
REQ-024 grant SHALL never have more than one bit set in any cycle.

Reset
REQ-025 rst_n=0 SHALL immediately (asynchronously) force state=IDLE, grant=0, grant_valid=0, grant_id=0, timeout=0, ptr=0, hold count=0.
REQ-026 Reset mid-BUSY SHALL drop the grant without a timeout pulse; first arbitration after deassert starts from ptr=0.
REQ-027 While rst_n=0 all outputs SHALL hold reset values regardless of req/done.

Verification
REQ-028 REQ_WIDTH=4, req=4'b1111 through reset, deassert rst_n -> first edge: grant=0001, grant_id=0, grant_valid=1.
REQ-029 req=1111 held, done pulsed 2nd grant cycle each time -> grant sequence 0001,0001,0000,0010,0010,0000,0100,...,1000,0000,0001 (wrap).
REQ-030 ptr=3 (after requester 2 released), req=0100 -> grant=0100, grant_id=2 (wrap search 3,0,1,2).
REQ-031 MAX_HOLD=4, req=0010 held, done=0 -> grant=0010 for 4 cycles, then grant=0, timeout=1 one cycle, next grant 0010 after bubble.
REQ-032 Holder requester 1 drops req[1] in 3rd grant cycle, req[3]=1 -> grant=0 next cycle, then grant=1000; timeout stays 0.
REQ-033 rst_n pulsed low mid-BUSY with grant=0100 -> grant=0 before next clock edge; after release with req=1111 -> grant=0001.

Source files
------------

// File: rtl/round_robin_lock_arbiter.sv
// Round-robin arbiter that locks the grant to one requester until it finishes,
// drops its request, or exceeds MAX_HOLD cycles (forced release with a timeout pulse).
module round_robin_lock_arbiter #(
   parameter int unsigned REQ_WIDTH = 4,
   parameter int unsigned MAX_HOLD  = 16,
   localparam int unsigned IDW      = (REQ_WIDTH > 1) ? $clog2(REQ_WIDTH) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [REQ_WIDTH-1:0] req,
   input  logic                 done,
   output logic [REQ_WIDTH-1:0] grant,
   output logic                 grant_valid,
   output logic [IDW-1:0]       grant_id,
   output logic                 timeout
);

   // Hold counter must represent MAX_HOLD itself; one bit is enough when the timeout is disabled.
   localparam int unsigned HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   state_e                 state_q, state_d;
   logic [IDW-1:0]         ptr_q, ptr_d;
   logic [HW-1:0]          hold_q, hold_d;
   logic [REQ_WIDTH-1:0]   grant_q, grant_d;
   logic [IDW-1:0]         grant_id_q, grant_id_d;
   logic                   grant_valid_q, grant_valid_d;
   logic                   timeout_q, timeout_d;

   logic                   pick_found;
   logic [IDW-1:0]         pick_idx;
   logic                   holder_req;
   logic                   hold_hit;

   // Find the first active request scanning from ptr upward with wrap-around.
   always_comb begin
      int unsigned j;
      pick_found = 1'b0;
      pick_idx   = '0;
      j          = 0;
      for (int unsigned k = 0; k < REQ_WIDTH; k++) begin
         j = 32'(ptr_q) + k;
         if (j >= REQ_WIDTH) begin
            j = j - REQ_WIDTH;
         end
         if (!pick_found && req[IDW'(j)]) begin
            pick_found = 1'b1;
            pick_idx   = IDW'(j);
         end
      end
   end

   // Next-state and registered-output computation for the IDLE/BUSY lock FSM.
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      hold_d        = hold_q;
      grant_d       = grant_q;
      grant_id_d    = grant_id_q;
      grant_valid_d = grant_valid_q;
      timeout_d     = 1'b0;
      holder_req    = req[grant_id_q];
      hold_hit      = (MAX_HOLD > 0) && (hold_q == HW'(MAX_HOLD));

      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d            = BUSY;
               grant_d            = '0;
               grant_d[pick_idx]  = 1'b1;
               grant_id_d         = pick_idx;
               grant_valid_d      = 1'b1;
               hold_d             = HW'(1);
            end
         end
         BUSY: begin
            if (done || !holder_req || hold_hit) begin
               state_d       = IDLE;
               grant_d       = '0;
               grant_id_d    = '0;
               grant_valid_d = 1'b0;
               hold_d        = '0;
               // A release caused by done or a dropped request is never a timeout.
               timeout_d     = hold_hit && !done && holder_req;
               if (grant_id_q == IDW'(REQ_WIDTH - 1)) begin
                  ptr_d = '0;
               end else begin
                  ptr_d = grant_id_q + IDW'(1);
               end
            end else if (hold_q != '1) begin
               hold_d = hold_q + HW'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         hold_q        <= '0;
         grant_q       <= '0;
         grant_id_q    <= '0;
         grant_valid_q <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         hold_q        <= hold_d;
         grant_q       <= grant_d;
         grant_id_q    <= grant_id_d;
         grant_valid_q <= grant_valid_d;
         timeout_q     <= timeout_d;
      end
   end

   assign grant       = grant_q;
   assign grant_valid = grant_valid_q;
   assign grant_id    = grant_id_q;
   assign timeout     = timeout_q;

endmodule

// File: tb/tb_round_robin_lock_arbiter.sv
// Directed bench for round_robin_lock_arbiter: a 4-requester instance with MAX_HOLD=4
// and a single-requester instance with MAX_HOLD=2.
module tb_round_robin_lock_arbiter;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic       done;
   logic [3:0] grant;
   logic       grant_valid;
   logic [1:0] grant_id;
   logic       timeout;

   logic [0:0] req_b;
   logic       done_b;
   logic [0:0] grant_b;
   logic       grant_valid_b;
   logic [0:0] grant_id_b;
   logic       timeout_b;

   int n_cmp;
   int n_bad;

   round_robin_lock_arbiter #(.REQ_WIDTH(4), .MAX_HOLD(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .done        (done),
      .grant       (grant),
      .grant_valid (grant_valid),
      .grant_id    (grant_id),
      .timeout     (timeout)
   );

   round_robin_lock_arbiter #(.REQ_WIDTH(1), .MAX_HOLD(2)) dut_b (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req_b),
      .done        (done_b),
      .grant       (grant_b),
      .grant_valid (grant_valid_b),
      .grant_id    (grant_id_b),
      .timeout     (timeout_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {grant, grant_valid, grant_id, timeout} derived from an expected grant vector.
   function automatic logic [7:0] ex(input logic [3:0] g, input logic to);
      logic [1:0] id;
      case (g)
         4'b0010: id = 2'd1;
         4'b0100: id = 2'd2;
         4'b1000: id = 2'd3;
         default: id = 2'd0;
      endcase
      return {g, |g, id, to};
   endfunction

   function automatic logic [7:0] obs();
      return {grant, grant_valid, grant_id, timeout};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      req    = '0;
      done   = 1'b0;
      req_b  = '0;
      done_b = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [7:0] e;
      rst_n  = 1'b0;
      req    = 4'b1111;
      done   = 1'b1;
      req_b  = 1'b1;
      done_b = 1'b0;
      #2;
      e = ex(4'b0000, 1'b0);
      n_cmp++;
      if (obs() !== e) begin
         n_bad++;
         $display("FAIL reset_async got=%b want=%b", obs(), e);
      end
      step();
      step();
      step();
      n_cmp++;
      if (obs() !== e) begin
         n_bad++;
         $display("FAIL reset_held got=%b want=%b", obs(), e);
      end
      n_cmp++;
      if ({grant_b, grant_valid_b, grant_id_b, timeout_b} !== 4'b0000) begin
         n_bad++;
         $display("FAIL reset_held_w1 got=%b want=0000",
                  {grant_b, grant_valid_b, grant_id_b, timeout_b});
      end
      done  = 1'b0;
      req_b = 1'b0;
      rst_n = 1'b1;
      step();
      e = ex(4'b0001, 1'b0);
      n_cmp++;
      if (obs() !== e) begin
         n_bad++;
         $display("FAIL reset_first_grant got=%b want=%b", obs(), e);
      end
   endtask

   // Row = {req, done, expected grant, expected timeout}; inputs applied before the edge.
   task automatic test_rotation();
      logic [9:0] t [13];
      logic [7:0] e;
      t = '{10'b1111_0_0001_0, 10'b1111_0_0001_0, 10'b1111_1_0000_0,
            10'b1111_0_0010_0, 10'b1111_0_0010_0, 10'b1111_1_0000_0,
            10'b1111_0_0100_0, 10'b1111_0_0100_0, 10'b1111_1_0000_0,
            10'b1111_0_1000_0, 10'b1111_0_1000_0, 10'b1111_1_0000_0,
            10'b1111_0_0001_0};
      do_reset();
      for (int i = 0; i < 13; i++) begin
         req  = t[i][9:6];
         done = t[i][5];
         step();
         e = ex(t[i][4:1], t[i][0]);
         n_cmp++;
         if (obs() !== e) begin
            n_bad++;
            $display("FAIL rotation[%0d] got=%b want=%b", i, obs(), e);
         end
      end
   endtask

   task automatic test_wrap_search();
      logic [9:0] t [8];
      logic [7:0] e;
      t = '{10'b0100_0_0100_0, 10'b0100_1_0000_0, 10'b0100_0_0100_0,
            10'b0100_1_0000_0, 10'b0011_0_0001_0, 10'b0111_0_0001_0,
            10'b0110_0_0000_0, 10'b0110_0_0010_0};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         req  = t[i][9:6];
         done = t[i][5];
         step();
         e = ex(t[i][4:1], t[i][0]);
         n_cmp++;
         if (obs() !== e) begin
            n_bad++;
            $display("FAIL wrap_search[%0d] got=%b want=%b", i, obs(), e);
         end
      end
   endtask

   task automatic test_timeout();
      logic [9:0] t [12];
      logic [7:0] e;
      t = '{10'b0010_0_0010_0, 10'b0010_0_0010_0, 10'b0010_0_0010_0,
            10'b0010_0_0010_0, 10'b0010_0_0000_1, 10'b0010_0_0010_0,
            10'b0010_0_0010_0, 10'b0010_0_0010_0, 10'b0010_0_0010_0,
            10'b0010_1_0000_0, 10'b0010_0_0010_0, 10'b0000_0_0000_0};
      do_reset();
      for (int i = 0; i < 12; i++) begin
         req  = t[i][9:6];
         done = t[i][5];
         step();
         e = ex(t[i][4:1], t[i][0]);
         n_cmp++;
         if (obs() !== e) begin
            n_bad++;
            $display("FAIL timeout[%0d] got=%b want=%b", i, obs(), e);
         end
      end
   endtask

   task automatic test_drop_req();
      logic [9:0] t [8];
      logic [7:0] e;
      t = '{10'b0001_0_0001_0, 10'b0001_1_0000_0, 10'b1010_0_0010_0,
            10'b1010_0_0010_0, 10'b1010_0_0010_0, 10'b1000_0_0000_0,
            10'b1000_0_1000_0, 10'b0000_0_0000_0};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         req  = t[i][9:6];
         done = t[i][5];
         step();
         e = ex(t[i][4:1], t[i][0]);
         n_cmp++;
         if (obs() !== e) begin
            n_bad++;
            $display("FAIL drop_req[%0d] got=%b want=%b", i, obs(), e);
         end
      end
   endtask

   task automatic test_reset_mid_busy();
      logic [7:0] e;
      do_reset();
      req = 4'b0100;
      step();
      e = ex(4'b0100, 1'b0);
      n_cmp++;
      if (obs() !== e) begin
         n_bad++;
         $display("FAIL midrst_grant got=%b want=%b", obs(), e);
      end
      #2;
      rst_n = 1'b0;
      #1;
      e = ex(4'b0000, 1'b0);
      n_cmp++;
      if (obs() !== e) begin
         n_bad++;
         $display("FAIL midrst_async got=%b want=%b", obs(), e);
      end
      req = 4'b1111;
      step();
      n_cmp++;
      if (obs() !== e) begin
         n_bad++;
         $display("FAIL midrst_held got=%b want=%b", obs(), e);
      end
      rst_n = 1'b1;
      step();
      e = ex(4'b0001, 1'b0);
      n_cmp++;
      if (obs() !== e) begin
         n_bad++;
         $display("FAIL midrst_after got=%b want=%b", obs(), e);
      end
   endtask

   // Row = {req_b, done_b, expected grant_b, expected timeout_b}; grant_id_b must stay 0.
   task automatic test_width1();
      logic [3:0] t [7];
      logic [3:0] o;
      logic [3:0] e;
      t = '{4'b1_0_1_0, 4'b1_0_1_0, 4'b1_0_0_1, 4'b1_0_1_0,
            4'b1_1_0_0, 4'b1_0_1_0, 4'b0_0_0_0};
      do_reset();
      for (int i = 0; i < 7; i++) begin
         req_b  = t[i][3];
         done_b = t[i][2];
         step();
         o = {grant_b, grant_valid_b, grant_id_b, timeout_b};
         e = {t[i][1], t[i][1], 1'b0, t[i][0]};
         n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL width1[%0d] got=%b want=%b", i, o, e);
         end
      end
   endtask

   initial begin
      n_cmp  = 0;
      n_bad  = 0;
      rst_n  = 1'b0;
      req    = '0;
      done   = 1'b0;
      req_b  = '0;
      done_b = 1'b0;
      test_reset();
      test_rotation();
      test_wrap_search();
      test_timeout();
      test_drop_req();
      test_reset_mid_busy();
      test_width1();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
